// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - Oversampled UART receiver with majority voting and a buffered receive FIFO
//
// Purpose:
//   Recovers characters from an asynchronous RX line. Each bit is oversampled and decided
//   by a 3-sample majority vote around mid-bit. Each received character and its error
//   flags are pushed into a FIFO that a sink drains through a valid/ready port.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   serial_in        asynchronous RX line, idle high
//   data_out         head-of-FIFO character
//   frame_err        head entry: a stop bit sampled 0
//   parity_err       head entry: parity mismatch
//   data_out_valid   FIFO not empty
//   data_out_ready   sink accepts the head entry
//   fifo_count       number of entries held
//   overrun          sticky: a character was dropped because the FIFO was full
//   overrun_clear    pulse that clears overrun
//   rx_busy          receiver is not idle

module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clear,
    output logic                          rx_busy
);

    localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int EW       = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_line_prev;
    logic [1:0]             r_hist;
    logic [TW-1:0]          r_tick_cnt;
    logic [IW-1:0]          r_tick_idx;
    logic [BW-1:0]          r_bit_cnt;
    logic                   r_stop_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_frame_err;

    logic [EW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_overrun;

    logic                   w_fall;
    logic                   w_tick;
    logic                   w_mid;
    logic                   w_vote;
    logic                   w_par_exp;
    logic                   w_frame_final;
    logic                   w_start;
    logic                   w_shift;
    logic                   w_par_chk;
    logic                   w_stop_chk;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_wr_en;
    logic [EW-1:0]          w_entry;

    assign w_fall        = r_line_prev & ~r_sync2;
    assign w_tick        = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_mid         = w_tick && (r_tick_idx == IW'(OVERSAMPLE / 2 + 1));
    // History holds the samples from ticks OVERSAMPLE/2-1 and OVERSAMPLE/2; the live line
    // value is the third sample at the decision tick.
    assign w_vote        = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
    assign w_par_exp     = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
    assign w_frame_final = r_frame_err | ~w_vote;
    assign w_entry       = {w_frame_final, r_par_err, r_shift};

    // Input synchroniser and start-edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
        end else begin
            r_sync1     <= serial_in;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    // Oversample tick generator, realigned to the detected start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_tick_idx <= '0;
            r_hist     <= 2'b11;
        end else if (w_start) begin
            r_tick_cnt <= '0;
            r_tick_idx <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_tick_idx <= (r_tick_idx == IW'(OVERSAMPLE - 1)) ? '0 : r_tick_idx + 1'b1;
            r_hist     <= {r_hist[0], r_sync2};
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_par_chk    = 1'b0;
        w_stop_chk   = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_start      = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_mid) begin
                    w_state_next = w_vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    w_par_chk    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid) begin
                    w_stop_chk = 1'b1;
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_push = 1'b1;
                        // A break (all-zero data, low stop) is recorded once; wait for the
                        // line to recover before hunting for the next start edge.
                        w_state_next = ((r_shift == '0) && w_frame_final) ? S_BREAK : S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (r_sync2) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Per-character datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt   <= '0;
                r_stop_cnt  <= 1'b0;
                r_par_err   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_par_chk) begin
                r_par_err <= (w_vote != w_par_exp);
            end
            if (w_stop_chk) begin
                r_frame_err <= w_frame_final;
                r_stop_cnt  <= r_stop_cnt + 1'b1;
            end
        end
    end

    // Receive FIFO
    assign w_pop   = (r_count != '0) && data_out_ready;
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // Setting wins over a simultaneous clear so a drop is never lost.
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign {frame_err, parity_err, data_out} = r_mem[r_rd_ptr];
    assign data_out_valid = (r_count != '0);
    assign fifo_count     = r_count;
    assign overrun        = r_overrun;
    assign rx_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Scoreboard bench for uart_rx_fifo (8N1 instance and 8E1 instance)

module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 32;

    logic       clk;
    logic       rst_n;
    logic       line_a, ready_a, ovc_a;
    logic [7:0] data_a;
    logic       ferr_a, perr_a, valid_a, ovr_a, busy_a;
    logic [3:0] count_a;

    logic       line_p, ready_p, ovc_p;
    logic [7:0] data_p;
    logic       ferr_p, perr_p, valid_p, ovr_p, busy_p;
    logic [3:0] count_p;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] q_a [$];
    logic [9:0] q_p [$];

    uart_rx_fifo #(
        .CLOCK_FREQ(3_686_400), .BAUD_RATE(115_200), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .serial_in(line_a),
        .data_out(data_a), .frame_err(ferr_a), .parity_err(perr_a),
        .data_out_valid(valid_a), .data_out_ready(ready_a),
        .fifo_count(count_a), .overrun(ovr_a), .overrun_clear(ovc_a),
        .rx_busy(busy_a)
    );

    uart_rx_fifo #(
        .CLOCK_FREQ(3_686_400), .BAUD_RATE(115_200), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)
    ) u_dut_par (
        .clk(clk), .rst_n(rst_n), .serial_in(line_p),
        .data_out(data_p), .frame_err(ferr_p), .parity_err(perr_p),
        .data_out_valid(valid_p), .data_out_ready(ready_p),
        .fifo_count(count_p), .overrun(ovr_p), .overrun_clear(ovc_p),
        .rx_busy(busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives n bits LSB first, one bit time each, on the selected line.
    task automatic send_bits(input int ch, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) line_a = bits[i];
            else         line_p = bits[i];
            clks(BIT_CLKS);
        end
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_bits(0, {3'b000, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic send_8e1(input logic [7:0] d, input logic p);
        send_bits(1, {2'b00, 1'b1, p, d, 1'b0}, 11);
    endtask

    task automatic drain_a(input string name);
        ready_a = 1'b1;
        for (int i = 0; i < 400 && (q_a.size() != 0 || valid_a); i++) clks(1);
        check(name, q_a.size(), 0);
    endtask

    // Scoreboard monitors: every accepted head entry must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_entry", {22'd0, ferr_a, perr_a, data_a}, 32'hFFFF_FFFF);
            end else begin
                check("a_entry", {22'd0, ferr_a, perr_a, data_a}, {22'd0, q_a.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_p && ready_p) begin
            if (q_p.size() == 0) begin
                check("p_unexpected_entry", {22'd0, ferr_p, perr_p, data_p}, 32'hFFFF_FFFF);
            end else begin
                check("p_entry", {22'd0, ferr_p, perr_p, data_p}, {22'd0, q_p.pop_front()});
            end
        end
    end

    initial begin
        logic seen_busy;
        rst_n = 1'b0; line_a = 1'b1; line_p = 1'b1;
        ready_a = 1'b0; ready_p = 1'b1; ovc_a = 1'b0; ovc_p = 1'b0;
        clks(5);
        check("reset_valid", valid_a, 0);
        check("reset_count", count_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_overrun", ovr_a, 0);
        check("reset_head", {ferr_a, perr_a, data_a}, 0);
        rst_n = 1'b1;
        clks(5);

        // 8N1 0xA5, held in the FIFO then drained
        q_a.push_back({2'b00, 8'hA5});
        send_bits(0, {3'b000, 1'b1, 8'hA5, 1'b0}, 9);
        check("a5_not_early", valid_a, 0);
        line_a = 1'b1;
        clks(BIT_CLKS);
        check("a5_valid", valid_a, 1);
        check("a5_count", count_a, 1);
        drain_a("a5_drain");

        // Short low glitch on an idle line
        seen_busy = 1'b0;
        line_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) line_a = 1'b1;
            clks(1);
            if (busy_a) seen_busy = 1'b1;
        end
        check("glitch_busy_seen", seen_busy, 1);
        check("glitch_idle", busy_a, 0);
        check("glitch_count", count_a, 0);

        // Overrun: 9 characters into an 8-deep FIFO with no sink
        ready_a = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) q_a.push_back({2'b00, 8'(i)});
            send_8n1(8'(i));
        end
        check("ovr_count", count_a, 8);
        check("ovr_flag", ovr_a, 1);
        drain_a("ovr_drain");
        check("ovr_still_set", ovr_a, 1);
        ovc_a = 1'b1;
        clks(1);
        ovc_a = 1'b0;
        check("ovr_cleared", ovr_a, 0);

        // Break: line low 20 bit times, then 0x55
        ready_a = 1'b0;
        q_a.push_back({2'b10, 8'h00});
        q_a.push_back({2'b00, 8'h55});
        line_a = 1'b0;
        clks(20 * BIT_CLKS);
        line_a = 1'b1;
        clks(2 * BIT_CLKS);
        send_8n1(8'h55);
        check("brk_count", count_a, 2);
        drain_a("brk_drain");

        // Reset during data bit 3, with one character already buffered
        ready_a = 1'b0;
        send_8n1(8'h11);
        check("rst_pre_count", count_a, 1);
        send_bits(0, {3'b000, 1'b1, 8'h77, 1'b0}, 4);
        clks(16);
        check("rst_pre_busy", busy_a, 1);
        rst_n = 1'b0;
        line_a = 1'b1;
        #1;
        check("rst_valid", valid_a, 0);
        check("rst_count", count_a, 0);
        check("rst_busy", busy_a, 0);
        clks(3);
        rst_n = 1'b1;
        clks(2 * BIT_CLKS);
        ready_a = 1'b1;
        q_a.push_back({2'b00, 8'h3C});
        send_8n1(8'h3C);
        drain_a("rst_next_frame");

        // Even parity instance: 0x03 has even ones, so parity bit 1 is wrong
        q_p.push_back({2'b01, 8'h03});
        send_8e1(8'h03, 1'b1);
        q_p.push_back({2'b00, 8'h03});
        send_8e1(8'h03, 1'b0);
        q_p.push_back({2'b00, 8'h07});
        send_8e1(8'h07, 1'b1);
        for (int i = 0; i < 400 && q_p.size() != 0; i++) clks(1);
        check("par_drain", q_p.size(), 0);

        clks(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
